// File: rtl/mult16_seq.sv
// mult16_seq: sequential unsigned 16x16 -> 32 shift-add multiplier.
// Ports: clk, rst (async high), start/a/b in; busy, done, p out.
// CLA16 (defined below): the 16-bit carry-lookahead adder used per step.
module mult16_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] m_q, m_d;
    logic [15:0] h_q, h_d;
    logic [15:0] l_q, l_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] p_q, p_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_co;
    logic [31:0] shifted;

    assign add_b = l_q[0] ? m_q : 16'h0000;

    CLA16 u_cla (
        .a    (h_q),
        .b    (add_b),
        .c0   (1'b0),
        .sum  (add_sum),
        .cout (add_co)
    );

    // 33-bit {cout, H, L} shifted right by one; cout lands in H's MSB.
    assign shifted = {add_co, add_sum, l_q[15:1]};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        h_d     = h_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    l_d     = b;
                    h_d     = 16'h0000;
                    cnt_d   = 5'd0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                h_d    = shifted[31:16];
                l_d    = shifted[15:0];
                cnt_d  = cnt_q + 5'd1;
                busy_d = 1'b1;
                if (cnt_q == 5'd15) begin
                    p_d     = shifted;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= 16'h0000;
            h_q     <= 16'h0000;
            l_q     <= 16'h0000;
            cnt_q   <= 5'd0;
            p_q     <= 32'h0000_0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            h_q     <= h_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// CLA16: 16-bit carry-lookahead adder, four 4-bit lookahead groups
// with a second lookahead level across the group carries.
module CLA16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c0,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] pr;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g  = a & b;
    assign pr = a ^ b;

    // Group carries are flattened from gg/gp so no carry ripples.
    assign gc[0] = c0;
    assign gc[1] = gg[0] | (gp[0] & c0);
    assign gc[2] = gg[1] | (gp[1] & gg[0])
                 | (gp[1] & gp[0] & c0);
    assign gc[3] = gg[2] | (gp[2] & gg[1])
                 | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & c0);
    assign gc[4] = gg[3] | (gp[3] & gg[2])
                 | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
    assign cout  = gc[4];

    for (genvar i = 0; i < 4; i++) begin : g_grp
        logic       ci;
        logic [3:0] gi;
        logic [3:0] pi;
        logic [3:0] cc;

        assign ci = gc[i];
        assign gi = g[4*i +: 4];
        assign pi = pr[4*i +: 4];

        assign gg[i] = gi[3] | (pi[3] & gi[2])
                     | (pi[3] & pi[2] & gi[1])
                     | (pi[3] & pi[2] & pi[1] & gi[0]);
        assign gp[i] = &pi;

        assign cc[0] = ci;
        assign cc[1] = gi[0] | (pi[0] & ci);
        assign cc[2] = gi[1] | (pi[1] & gi[0])
                     | (pi[1] & pi[0] & ci);
        assign cc[3] = gi[2] | (pi[2] & gi[1])
                     | (pi[2] & pi[1] & gi[0])
                     | (pi[2] & pi[1] & pi[0] & ci);

        assign sum[4*i +: 4] = pi ^ cc;
    end

endmodule

// File: tb/tb_mult16_seq.sv
// tb_mult16_seq: randomized self-checking bench for mult16_seq.
// Reference: product = a*b, done 16 edges after the accepting edge.
module tb_mult16_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] p;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_p;

    mult16_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // mode 0: start low, 1: random start, 2: start held with same
    // operands, 3: start with 7*7 only before edges 5 and 17.
    task automatic drive(input int e, input int mode,
                         input logic [15:0] ha,
                         input logic [15:0] hb);
        if (mode == 2) begin
            start = 1'b1;
            a     = ha;
            b     = hb;
        end else if (mode == 3) begin
            start = (e == 5) || (e == 17);
            a     = 16'd7;
            b     = 16'd7;
        end else begin
            start = (mode == 1) ? 1'($urandom) : 1'b0;
            a     = 16'($urandom);
            b     = 16'($urandom);
        end
    endtask

    task automatic run_op(input logic [15:0] ha,
                          input logic [15:0] hb,
                          input int mode);
        logic [31:0] prod;
        prod = 32'(ha) * 32'(hb);
        @(negedge clk);
        start = 1'b1;
        a     = ha;
        b     = hb;
        @(posedge clk);
        for (int e = 1; e <= 16; e++) begin
            #1;
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            check("p_hold_run", p, exp_p);
            @(negedge clk);
            drive(e, mode, ha, hb);
            @(posedge clk);
        end
        #1;
        exp_p = prod;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("p_result", p, exp_p);
        @(negedge clk);
        drive(17, mode, ha, hb);
        @(posedge clk);
        #1;
        check("done_clear", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("p_held", p, exp_p);
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            a     = 16'($urandom);
            b     = 16'($urandom);
            @(posedge clk);
            #1;
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_p", p, exp_p);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_p    = 32'h0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_p", p, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h0003, 16'h0005, 0);
        check("basic_p", p, 32'h0000_000F);
        idle_wait(3);
        run_op(16'hFFFF, 16'hFFFF, 0);
        check("max_p", p, 32'hFFFE_0001);
        run_op(16'h8000, 16'h0002, 1);
        check("carry_p", p, 32'h0001_0000);
        idle_wait(2);
        run_op(16'h0000, 16'h1234, 0);
        check("zero_p", p, 32'h0);
        run_op(16'h1234, 16'h0001, 0);
        check("ident_p", p, 32'h0000_1234);

        run_op(16'h0002, 16'h0003, 3);
        check("ign_p", p, 32'h0000_0006);
        idle_wait(20);

        // Reset in the middle of a run drops everything to zero.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h00FF;
        b     = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_p = 32'h0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_p", p, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0010, 16'h0010, 0);
        check("post_rst_p", p, 32'h0000_0100);

        for (int k = 0; k < 3; k++) begin
            run_op(16'h0002, 16'h0003, 2);
            check("b2b_p", p, 32'h0000_0006);
        end
        idle_wait(2);

        for (int k = 0; k < 10; k++) begin
            run_op(16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 1)));
            if ((k % 3) == 0) idle_wait(1);
        end
        idle_wait(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult16_seq.md
Name: mult16_seq

Overview:
- Sequential unsigned 16x16 -> 32-bit shift-add multiplier for the datapath's multiply operation.
- Each iteration's partial-sum add is done by one instance of the existing 16-bit carry-lookahead adder CLA16, with c0 tied to 0.
- Uses a start/busy/done handshake with the control unit.
- The result is registered and held stable until the next operation completes.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported because it is fixed by the CLA16 adder. The iteration counter is 5 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply. Sampled only in IDLE.
- a  input  16  multiplicand, captured on the accepted start edge.
- b  input  16  multiplier, captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: p holds a new valid result.
- p  output  32  product register.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, p=0, internal regs and counter=0. Reset asserted mid-operation aborts immediately with no partial result. After release, the next start behaves normally.
- Internal registers:
  - M[15:0]: multiplicand.
  - H[15:0]: high accumulator.
  - L[15:0]: multiplier/low product.
  - cnt[4:0]: iteration counter.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a clock edge: M<=a, L<=b, H<=0, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), each edge:
  - Adder inputs are H and (L[0] ? M : 0). The adder gives {cout, sum}.
  - {H, L} <= {cout, sum, L[15:1]}, which is a 33-bit shift right by 1.
  - cnt <= cnt+1.
  - On the edge where cnt==15 (the 16th iteration): p <= shifted {H, L} value, then go to DONE.
- DONE (done=1, busy=0, one cycle): unconditionally return to IDLE. start is ignored in DONE.
- Latency and timing:
  - An accepted start at edge 0 gives RUN on edges 1..16.
  - p updates and done is high between edges 16 and 17.
  - IDLE resumes after edge 17.
  - The earliest next accepted start is edge 18. start held high continuously yields one result every 18 cycles.
- start while busy or done is ignored. No queuing. a and b are don't-care outside the accepting edge.
- p changes only on the final RUN edge or on reset. It is held across IDLE and the next operation's RUN cycles.
- Arithmetic:
  - Unsigned. The product always fits 32 bits, so there is no overflow.
  - The adder's cout is kept in H's shift-in bit and is never dropped.
- Sequential regs use non-blocking assignment with async reset in the sensitivity list. There are no latches, and all state outputs are registered.

Test Plan:
- Basic: a=0x0003, b=0x0005, start pulsed at edge 0 -> busy=1 during edges 1..16. After edge 16: done=1 for exactly one cycle and p=0x0000000F. After edge 17: done=0 and p stays 0x0000000F.
- Carry path: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001. Also a=0x8000, b=0x0002 -> p=0x00010000.
- Zero and identity: a=0x0000, b=0x1234 -> p=0. Then a=0x1234, b=0x0001 -> p=0x00001234. done pulses once per operation.
- Ignored start: start a=2, b=3, then assert start with a=7, b=7 at edges 5 and 17 -> only p=0x00000006 is produced. No second done occurs without a start in IDLE.
- Reset mid-op: start a=0x00FF, b=0x0100, assert rst at edge 8 -> busy=0, done=0, p=0 immediately. After release, a=0x0010, b=0x0010 -> p=0x00000100 after 17 cycles.
- Back-to-back: start held high with a=0x0002, b=0x0003 -> done pulses every 18 cycles with p=0x00000006 each time, and busy is never high during a DONE cycle.
